// File: rtl/dff_pipe_elastic_pkg.sv
// rtl/dff_pipe_elastic_pkg.sv - shared limits and helpers for the elastic pipeline register
package dff_pipe_elastic_pkg;

    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 16;

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// rtl/dff_pipe_stage.sv - one valid+data register slot with load enable and flush
module dff_pipe_stage #(
    parameter int            DW      = 1,
    parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          load,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          valid,
    output logic [DW-1:0] data
);

    logic          valid_d;
    logic          valid_q;
    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;

    // Data only follows a valid source so idle upstream X never lands here.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = src_valid;
            if (src_valid) begin
                data_d = src_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/dff_pipe_elastic.sv
// rtl/dff_pipe_elastic.sv - N-stage pipeline register with valid/ready flow control
module dff_pipe_elastic
    import dff_pipe_elastic_pkg::*;
#(
    parameter int            DW              = 1,
    parameter int            STAGES          = 2,
    parameter logic [DW-1:0] RST_VAL         = {DW{1'b0}},
    parameter int            BUBBLE_COLLAPSE = 1
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           FLUSH,
    input  logic                           I_VALID,
    output logic                           I_READY,
    input  logic [DW-1:0]                  I_DATA,
    output logic                           O_VALID,
    input  logic                           O_READY,
    output logic [DW-1:0]                  O_DATA,
    output logic [occ_width(STAGES)-1:0]   OCCUPANCY
);

    localparam int OW = occ_width(STAGES);

    logic [STAGES-1:0] v;
    logic [DW-1:0]     d [STAGES];
    logic [STAGES-1:0] r;
    logic [STAGES-1:0] load;
    logic              adv;
    logic              ready_acc;
    logic [OW-1:0]     occ_count;

    // Ready ripples from the output back to stage 0; a hole lets upstream move.
    always_comb begin
        ready_acc = O_READY;
        r         = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready_acc = ~v[k] | ready_acc;
            r[k]      = ready_acc;
        end
    end

    assign adv     = O_READY | ~v[STAGES-1];
    assign I_READY = ((BUBBLE_COLLAPSE != 0) ? r[0] : adv) & ~FLUSH;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic          src_v;
            logic [DW-1:0] src_d;

            if (k == 0) begin : g_head
                assign src_v = I_VALID;
                assign src_d = I_DATA;
            end else begin : g_body
                assign src_v = v[k-1];
                assign src_d = d[k-1];
            end

            assign load[k] = (BUBBLE_COLLAPSE != 0) ? r[k] : adv;

            dff_pipe_stage #(
                .DW      (DW),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk       (CLK),
                .rst_n     (RST_N),
                .flush     (FLUSH),
                .load      (load[k]),
                .src_valid (src_v),
                .src_data  (src_d),
                .valid     (v[k]),
                .data      (d[k])
            );
        end
    endgenerate

    always_comb begin
        occ_count = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_count = occ_count + OW'(v[k]);
        end
    end

    assign OCCUPANCY = occ_count;
    assign O_VALID   = v[STAGES-1];
    assign O_DATA    = d[STAGES-1];

`ifndef SYNTHESIS
`ifdef NCPU_ENABLE_ASSERT
    always @(posedge CLK) begin
        if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin
            $fatal(1, "dff_pipe_elastic: STAGES=%0d out of range", STAGES);
        end
`ifdef NCPU_CHECK_X
        if (RST_N && I_VALID && $isunknown(I_DATA)) begin
            $fatal(1, "dff_pipe_elastic: I_DATA unknown while I_VALID");
        end
`endif
    end
`endif
`endif

endmodule
